pipelined_ripple_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor for the arithmetic datapath. It is the successor to the fixed 4-bit ripple adder. A WIDTH-bit operation is split into SEG-bit ripple segments, and each segment is resolved in its own registered stage, so carry-chain depth per cycle is SEG bits. It accepts one operation per cycle through a valid/ready handshake, supports add and subtract, and reports carry and signed overflow.

---
 rtl/pipelined_ripple_adder.sv | 95 +++++++++
 tb/tb_pipelined_ripple_adder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits resolved SEG bits per registered stage,
// one operation per cycle under a valid/ready handshake, with carry and signed overflow.
module pipelined_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op,
  output logic             c_op,
  output logic             ovf
);

  localparam int N = WIDTH / SEG;

  logic [N-1:0]     vld;
  logic [N-1:0]     cy;
  logic [WIDTH-1:0] res [N];
  logic [WIDTH-1:0] a_r [N];
  logic [WIDTH-1:0] b_r [N];
  logic             c_msb;

  logic             adv;
  logic [WIDTH-1:0] b_in;
  logic             cin0;
  logic [SEG-1:0]   sa [N];
  logic [SEG-1:0]   sb [N];
  logic [N-1:0]     sc;
  logic [SEG:0]     ss [N];

  assign adv      = !vld[N-1] | out_ready;
  assign in_ready = adv;
  assign b_in     = sub ? ~B : B;
  assign cin0     = sub | c_in;

  // Each stage consumes the low segment of the operands it received; the
  // remaining operand bits travel right-aligned so every stage reads [SEG-1:0].
  always_comb begin
    sa[0] = A[SEG-1:0];
    sb[0] = b_in[SEG-1:0];
    sc[0] = cin0;
    for (int i = 1; i < N; i++) begin
      sa[i] = a_r[i-1][SEG-1:0];
      sb[i] = b_r[i-1][SEG-1:0];
      sc[i] = cy[i-1];
    end
    for (int i = 0; i < N; i++) begin
      ss[i] = {1'b0, sa[i]} + {1'b0, sb[i]} + {{SEG{1'b0}}, sc[i]};
    end
  end

  // Result segments enter at the top and shift down, so after N stages
  // segment 0 sits at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      cy    <= '0;
      c_msb <= 1'b0;
      for (int i = 0; i < N; i++) begin
        res[i] <= '0;
        a_r[i] <= '0;
        b_r[i] <= '0;
      end
    end else if (adv) begin
      vld[0] <= in_valid;
      res[0] <= WIDTH'(ss[0][SEG-1:0]) << (WIDTH - SEG);
      cy[0]  <= ss[0][SEG];
      a_r[0] <= A >> SEG;
      b_r[0] <= b_in >> SEG;
      for (int i = 1; i < N; i++) begin
        vld[i] <= vld[i-1];
        res[i] <= (res[i-1] >> SEG) | (WIDTH'(ss[i][SEG-1:0]) << (WIDTH - SEG));
        cy[i]  <= ss[i][SEG];
        a_r[i] <= a_r[i-1] >> SEG;
        b_r[i] <= b_r[i-1] >> SEG;
      end
      // Carry into the MSB recovered from the MSB sum bit and its two addend bits.
      c_msb <= ss[N-1][SEG-1] ^ sa[N-1][SEG-1] ^ sb[N-1][SEG-1];
    end
  end

  assign out_valid = vld[N-1];
  assign op        = res[N-1];
  assign c_op      = cy[N-1];
  assign ovf       = cy[N-1] ^ c_msb;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder: directed vectors on 16/4, plus random traffic
// on 16/4, 8/8 and 32/8 checked against an arithmetic reference model.
module tb_pipelined_ripple_adder;

  typedef struct {
    logic [31:0] op;
    logic        c;
    logic        ovf;
    int unsigned acc;
    int unsigned stl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v       [3];
  logic        in_valid_v  [3];
  logic        out_ready_v [3];
  logic [31:0] a_v         [3];
  logic [31:0] b_v         [3];
  logic        cin_v       [3];
  logic        sub_v       [3];
  logic        in_ready_v  [3];
  logic        out_valid_v [3];
  logic [31:0] op_v        [3];
  logic        c_op_v      [3];
  logic        ovf_v       [3];

  int n_chk  = 0;
  int n_pass = 0;
  int acc_n [3];
  bit last_acc [3];

  task automatic check(string nm, logic [63:0] act, logic [63:0] expv);
    n_chk++;
    if (act !== expv) $display("FAIL %s: got %0h, required %0h", nm, act, expv);
    else n_pass++;
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    longint m, ua, ub, sa, sb, us, ssum;
    exp_t e;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (sub) begin
      us   = ua - ub;
      ssum = sa - sb;
      e.c  = (ua >= ub);
    end else begin
      us   = ua + ub + longint'(cin);
      ssum = sa + sb + longint'(cin);
      e.c  = (us >= m);
    end
    e.op  = 32'(us & (m - 1));
    e.ovf = (ssum >= m / 2) || (ssum < -(m / 2));
    e.acc = 0;
    e.stl = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W = (g == 0) ? 16 : ((g == 1) ? 8 : 32);
    localparam int S = (g == 0) ? 4 : 8;
    localparam int N = W / S;

    logic         rdy, ov, co, of;
    logic [W-1:0] res;
    exp_t         q [$];
    exp_t         held, e;
    int unsigned  cyc = 0;
    int unsigned  stalls = 0;
    int           pops = 0;
    bit           head_seen = 0;
    bit           holding = 0;

    pipelined_ripple_adder #(.WIDTH(W), .SEG(S)) u_dut (
      .clk      (clk),
      .rst      (rst_v[g]),
      .in_valid (in_valid_v[g]),
      .in_ready (rdy),
      .A        (a_v[g][W-1:0]),
      .B        (b_v[g][W-1:0]),
      .c_in     (cin_v[g]),
      .sub      (sub_v[g]),
      .out_valid(ov),
      .out_ready(out_ready_v[g]),
      .op       (res),
      .c_op     (co),
      .ovf      (of)
    );

    assign in_ready_v[g]  = rdy;
    assign out_valid_v[g] = ov;
    assign op_v[g]        = 32'(res);
    assign c_op_v[g]      = co;
    assign ovf_v[g]       = of;

    always @(negedge clk) begin
      cyc++;
      if (rst_v[g]) begin
        q.delete();
        head_seen = 0;
        holding   = 0;
      end else begin
        if (holding) begin
          check($sformatf("w%0d_hold_valid", W), ov, 1);
          check($sformatf("w%0d_hold_op", W), 32'(res), held.op);
          check($sformatf("w%0d_hold_flags", W), {co, of}, {held.c, held.ovf});
        end
        if (ov) begin
          check($sformatf("w%0d_result_expected", W), q.size() != 0, 1);
          if (q.size() != 0) begin
            if (!head_seen) begin
              check($sformatf("w%0d_latency", W), cyc, q[0].acc + N + (stalls - q[0].stl));
              head_seen = 1;
            end
            if (out_ready_v[g]) begin
              check($sformatf("w%0d_op", W), 32'(res), q[0].op);
              check($sformatf("w%0d_c_op", W), co, q[0].c);
              check($sformatf("w%0d_ovf", W), of, q[0].ovf);
              void'(q.pop_front());
              pops++;
              head_seen = 0;
            end
          end
        end
        holding = ov && !out_ready_v[g];
        if (holding) begin
          held.op  = 32'(res);
          held.c   = co;
          held.ovf = of;
          stalls++;
          check($sformatf("w%0d_in_ready_stall", W), rdy, 0);
        end
        if (in_valid_v[g] && rdy) begin
          e     = model(W, a_v[g], b_v[g], cin_v[g], sub_v[g]);
          e.acc = cyc;
          e.stl = stalls;
          q.push_back(e);
        end
      end
    end
  end

  task automatic step_all();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      last_acc[g] = !rst_v[g] && in_valid_v[g] && in_ready_v[g];
      if (last_acc[g]) acc_n[g]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_lit(string nm, logic [15:0] a, logic [15:0] b, logic cin, logic s,
                          logic [15:0] eop, logic ec, logic eov);
    int k;
    a_v[0] = 32'(a);
    b_v[0] = 32'(b);
    cin_v[0] = cin;
    sub_v[0] = s;
    in_valid_v[0] = 1'b1;
    out_ready_v[0] = 1'b1;
    step_all();
    in_valid_v[0] = 1'b0;
    k = 0;
    while (!out_valid_v[0] && k < 20) begin
      step_all();
      k++;
    end
    check({nm, "_latency"}, k, 3);
    check({nm, "_op"}, op_v[0], 32'(eop));
    check({nm, "_c_op"}, c_op_v[0], ec);
    check({nm, "_ovf"}, ovf_v[0], eov);
    step_all();
  endtask

  initial begin
    exp_t m;
    int   sent, p0;

    for (int g = 0; g < 3; g++) begin
      rst_v[g] = 1'b1;
      in_valid_v[g] = 1'b0;
      out_ready_v[g] = 1'b0;
      a_v[g] = '0;
      b_v[g] = '0;
      cin_v[g] = 1'b0;
      sub_v[g] = 1'b0;
      acc_n[g] = 0;
      last_acc[g] = 0;
    end

    // Pin the reference model itself to hand-computed values.
    m = model(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
    check("model_wrap", {m.op, m.c, m.ovf}, {32'h0000, 1'b1, 1'b0});
    m = model(16, 32'h8000, 32'h0001, 1'b0, 1'b1);
    check("model_sub_ovf", {m.op, m.c, m.ovf}, {32'h7FFF, 1'b1, 1'b1});
    m = model(8, 32'h00FF, 32'h0001, 1'b1, 1'b1);
    check("model_w8_sub", {m.op, m.c, m.ovf}, {32'h00FE, 1'b1, 1'b0});
    m = model(32, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
    check("model_w32_ovf", {m.op, m.c, m.ovf}, {32'h80000000, 1'b0, 1'b1});

    repeat (2) step_all();
    for (int g = 0; g < 3; g++) rst_v[g] = 1'b0;

    check("rst_out_valid", out_valid_v[0], 0);
    check("rst_op", op_v[0], 0);
    check("rst_c_op", c_op_v[0], 0);
    check("rst_ovf", ovf_v[0], 0);
    check("rst_in_ready", in_ready_v[0], 1);
    check("rst_w8_out_valid", out_valid_v[1], 0);
    check("rst_w32_out_valid", out_valid_v[2], 0);

    send_lit("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_lit("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_lit("add_chain",  16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
    send_lit("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_lit("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send_lit("sub_pos",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);

    // Back-to-back burst with a 5-cycle output stall in the middle.
    p0 = g_cfg[0].pops;
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid_v[0] = (sent < 8);
      a_v[0] = $urandom;
      b_v[0] = $urandom;
      cin_v[0] = 1'($urandom_range(0, 1));
      sub_v[0] = 1'($urandom_range(0, 1));
      out_ready_v[0] = !(c >= 4 && c < 9);
      step_all();
      if (last_acc[0]) sent++;
      if (c == 6) check("burst_in_ready_low", in_ready_v[0], 0);
    end
    in_valid_v[0] = 1'b0;
    out_ready_v[0] = 1'b1;
    check("burst_sent", sent, 8);
    check("burst_popped", g_cfg[0].pops - p0, 8);

    // Reset with three ops in flight.
    p0 = g_cfg[0].pops;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[0] = 1'b1;
      a_v[0] = 32'h1111 * (i + 1);
      b_v[0] = 32'h0101;
      cin_v[0] = 1'b0;
      sub_v[0] = 1'b0;
      step_all();
    end
    in_valid_v[0] = 1'b0;
    rst_v[0] = 1'b1;
    step_all();
    rst_v[0] = 1'b0;
    check("midrst_out_valid", out_valid_v[0], 0);
    check("midrst_op", op_v[0], 0);
    repeat (6) step_all();
    check("midrst_no_ghost", out_valid_v[0], 0);
    send_lit("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
    check("midrst_popped", g_cfg[0].pops - p0, 1);

    // Random sweep on all three configurations with random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int g = 0; g < 3; g++) begin
        in_valid_v[g] = ($urandom_range(0, 3) != 0);
        out_ready_v[g] = ($urandom_range(0, 9) < 7);
        a_v[g] = $urandom;
        b_v[g] = $urandom;
        cin_v[g] = 1'($urandom_range(0, 1));
        sub_v[g] = 1'($urandom_range(0, 1));
      end
      step_all();
    end
    for (int g = 0; g < 3; g++) begin
      in_valid_v[g] = 1'b0;
      out_ready_v[g] = 1'b1;
    end
    repeat (10) step_all();

    check("w16_count", g_cfg[0].pops, acc_n[0] - 3);
    check("w8_count", g_cfg[1].pops, acc_n[1]);
    check("w32_count", g_cfg[2].pops, acc_n[2]);
    check("w16_drained", out_valid_v[0], 0);
    check("w8_drained", out_valid_v[1], 0);
    check("w32_drained", out_valid_v[2], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
